// File: rtl/pwm_generator.sv
// PWM generator: edge-detects the divider output into ticks, counts ticks over a fixed period
// and drives a registered PWM output from a duty value that is updated only at period boundaries.
module pwm_generator #(
   parameter int WIDTH  = 8,
   parameter int PERIOD = 10
) (
   input  logic             Clock_i,
   input  logic             reset_i,
   input  logic             clk_div_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] duty_i,
   input  logic             duty_valid_i,
   output logic             duty_ready_o,
   output logic             pwm_o,
   output logic             period_end_o,
   output logic             running_o
);

   localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);
   localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PERIOD - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] duty_active_reg, duty_active_next;
   logic [WIDTH-1:0] shadow_reg, shadow_next;
   logic             pending_reg, pending_next;
   logic             clk_div_q_reg;
   logic             pwm_reg, pwm_next;
   logic             period_end_reg;
   logic             running_reg;

   logic             tick;
   logic             wrap;
   logic             accept;
   logic [WIDTH-1:0] duty_clamped;

   assign tick         = clk_div_i & ~clk_div_q_reg;
   assign wrap         = (state_reg == RUN) && tick && (cnt_reg == LAST_CNT);
   assign accept       = duty_valid_i && !pending_reg;
   assign duty_clamped = (duty_i > PERIOD_W) ? PERIOD_W : duty_i;

   assign duty_ready_o = ~pending_reg;
   assign pwm_o        = pwm_reg;
   assign period_end_o = period_end_reg;
   assign running_o    = running_reg;

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      duty_active_next = duty_active_reg;
      shadow_next      = shadow_reg;
      pending_next     = pending_reg;
      pwm_next         = (state_reg == RUN) && (cnt_reg < duty_active_reg);

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (tick && enable_i) begin
               state_next = RUN;
            end
            // Nothing is being generated, so a new duty can take effect immediately.
            if (accept) begin
               duty_active_next = duty_clamped;
            end
         end
         RUN: begin
            if (wrap) begin
               cnt_next = '0;
               if (!enable_i) begin
                  state_next = IDLE;
               end
               // Ready is low whenever pending is set, so reload and accept are exclusive.
               if (pending_reg) begin
                  duty_active_next = shadow_reg;
                  pending_next     = 1'b0;
               end else if (accept) begin
                  duty_active_next = duty_clamped;
               end
            end else begin
               if (tick) begin
                  cnt_next = cnt_reg + WIDTH'(1);
               end
               if (accept) begin
                  shadow_next  = duty_clamped;
                  pending_next = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge Clock_i) begin
      if (reset_i) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         duty_active_reg <= '0;
         shadow_reg      <= '0;
         pending_reg     <= 1'b0;
         clk_div_q_reg   <= 1'b0;
         pwm_reg         <= 1'b0;
         period_end_reg  <= 1'b0;
         running_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         duty_active_reg <= duty_active_next;
         shadow_reg      <= shadow_next;
         pending_reg     <= pending_next;
         clk_div_q_reg   <= clk_div_i;
         pwm_reg         <= pwm_next;
         period_end_reg  <= wrap;
         running_reg     <= (state_next == RUN);
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed scenarios plus random stimulus, every cycle compared
// against a tick/period-level reference model.
module tb_pwm_generator;

   localparam int WIDTH  = 8;
   localparam int PERIOD = 10;

   logic             Clock_i = 1'b0;
   logic             reset_i;
   logic             clk_div_i;
   logic             enable_i;
   logic [WIDTH-1:0] duty_i;
   logic             duty_valid_i;
   logic             duty_ready_o;
   logic             pwm_o;
   logic             period_end_o;
   logic             running_o;

   always #5 Clock_i = ~Clock_i;

   pwm_generator #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
      .Clock_i      (Clock_i),
      .reset_i      (reset_i),
      .clk_div_i    (clk_div_i),
      .enable_i     (enable_i),
      .duty_i       (duty_i),
      .duty_valid_i (duty_valid_i),
      .duty_ready_o (duty_ready_o),
      .pwm_o        (pwm_o),
      .period_end_o (period_end_o),
      .running_o    (running_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: position within the period in ticks, active duty, queue of pending duties.
   bit m_running;
   bit m_div_prev;
   int m_pos;
   int m_duty;
   int m_queue[$];
   bit e_pwm;
   bit e_pe;
   bit e_run;

   // Stimulus state applied by step().
   bit         s_rst;
   bit         s_div;
   bit         s_en;
   bit         s_valid;
   bit         toggle_div;
   logic [7:0] s_duty;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int clamp(input int d);
      return (d > PERIOD) ? PERIOD : d;
   endfunction

   task automatic model_step(input bit rst, input bit div, input bit en, input int duty, input bit valid);
      bit tick;
      bit accept;
      bit boundary;
      if (rst) begin
         m_running  = 0;
         m_div_prev = 0;
         m_pos      = 0;
         m_duty     = 0;
         m_queue.delete();
         e_pwm      = 0;
         e_pe       = 0;
         e_run      = 0;
         return;
      end
      tick     = div && !m_div_prev;
      accept   = valid && (m_queue.size() == 0);
      boundary = m_running && tick && (m_pos == PERIOD - 1);
      e_pwm    = m_running && (m_pos < m_duty);
      e_pe     = boundary;
      if (boundary) begin
         if (m_queue.size() != 0) m_duty = m_queue.pop_front();
         else if (accept)         m_duty = clamp(duty);
         m_pos     = 0;
         m_running = en;
      end else begin
         if (accept) begin
            if (m_running) m_queue.push_back(clamp(duty));
            else           m_duty = clamp(duty);
         end
         if (m_running && tick)          m_pos++;
         else if (!m_running && tick && en) m_running = 1;
      end
      e_run      = m_running;
      m_div_prev = div;
   endtask

   task automatic step();
      if (toggle_div) s_div = ~s_div;
      reset_i      = s_rst;
      clk_div_i    = s_div;
      enable_i     = s_en;
      duty_i       = s_duty;
      duty_valid_i = s_valid;
      model_step(s_rst, s_div, s_en, int'(s_duty), s_valid);
      @(posedge Clock_i);
      @(negedge Clock_i);
      cyc++;
      check("pwm_o", pwm_o, e_pwm);
      check("period_end_o", period_end_o, e_pe);
      check("running_o", running_o, e_run);
      check("duty_ready_o", duty_ready_o, m_queue.size() == 0);
      $display("cyc %0d rst=%0b div=%0b en=%0b v=%0b d=%0d -> pwm=%0b pe=%0b run=%0b rdy=%0b",
               cyc, s_rst, s_div, s_en, s_valid, s_duty, pwm_o, period_end_o, running_o, duty_ready_o);
      s_rst   = 0;
      s_valid = 0;
   endtask

   task automatic wait_pe();
      int k = 0;
      do begin
         step();
         k++;
      end while (period_end_o !== 1'b1 && k < 200);
      if (k >= 200) check("pe_timeout", 0, 1);
   endtask

   // inj_kind: 0 none, 1 send duty inj_val at step inj_at, 2 drop enable at step inj_at.
   task automatic measure_period(input int inj_at, input int inj_kind, input int inj_val,
                                 output int hi, output int len);
      hi  = 0;
      len = 0;
      do begin
         if (len == inj_at) begin
            if (inj_kind == 1) begin
               s_valid = 1;
               s_duty  = 8'(inj_val);
            end else if (inj_kind == 2) begin
               s_en = 0;
            end
         end
         step();
         len++;
         hi += int'(pwm_o === 1'b1);
         if (inj_kind == 1 && len == inj_at + 1) check("ready_low_after_accept", duty_ready_o, 0);
      end while (period_end_o !== 1'b1 && len < 200);
      if (len >= 200) check("period_timeout", 0, 1);
   endtask

   task automatic start_run(input int d);
      toggle_div = 0;
      s_div      = 0;
      s_en       = 0;
      s_rst      = 1;
      step();
      s_duty  = 8'(d);
      s_valid = 1;
      step();
      s_en       = 1;
      toggle_div = 1;
   endtask

   initial begin
      int hi;
      int len;
      int pe_seen;
      int k;
      int bd[3] = '{0, 10, 200};
      int bh[3] = '{0, 20, 20};

      s_rst = 1; s_div = 0; s_en = 0; s_valid = 0; s_duty = 0; toggle_div = 0;
      reset_i = 1; clk_div_i = 0; enable_i = 0; duty_i = 0; duty_valid_i = 0;
      @(negedge Clock_i);
      s_rst = 1; step();
      s_rst = 1; step();
      check("rst_pwm", pwm_o, 0);
      check("rst_running", running_o, 0);
      check("rst_period_end", period_end_o, 0);
      check("rst_ready", duty_ready_o, 1);

      // Steady PWM at duty 3.
      start_run(3);
      wait_pe();
      for (int i = 0; i < 2; i++) begin
         measure_period(-1, 0, 0, hi, len);
         check("steady_high_clocks", hi, 6);
         check("steady_period_clocks", len, 20);
      end

      // Boundary duties.
      for (int i = 0; i < 3; i++) begin
         start_run(bd[i]);
         wait_pe();
         measure_period(-1, 0, 0, hi, len);
         check("boundary_high_clocks", hi, bh[i]);
         check("boundary_period_clocks", len, 20);
      end

      // Duty update mid-period.
      start_run(3);
      wait_pe();
      measure_period(10, 1, 7, hi, len);
      check("update_cur_high", hi, 6);
      check("update_ready_after_wrap", duty_ready_o, 1);
      measure_period(-1, 0, 0, hi, len);
      check("update_next_high", hi, 14);

      // Stop request mid-period.
      start_run(3);
      wait_pe();
      measure_period(4, 2, 0, hi, len);
      check("stop_period_clocks", len, 20);
      check("stop_running", running_o, 0);
      pe_seen = 0;
      hi      = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         pe_seen += int'(period_end_o === 1'b1);
         hi      += int'(pwm_o === 1'b1);
      end
      check("stop_no_period_end", pe_seen, 0);
      check("stop_pwm_low", hi, 0);

      // Reset while pwm is high.
      start_run(10);
      wait_pe();
      k = 0;
      do begin
         step();
         k++;
      end while (pwm_o !== 1'b1 && k < 50);
      check("pwm_high_before_reset", pwm_o, 1);
      s_rst = 1;
      step();
      check("midrst_pwm", pwm_o, 0);
      check("midrst_running", running_o, 0);
      check("midrst_ready", duty_ready_o, 1);
      wait_pe();
      measure_period(-1, 0, 0, hi, len);
      check("restart_high_clocks", hi, 0);

      // Divider held high: at most one tick, so no wrap right after a period start.
      start_run(3);
      wait_pe();
      toggle_div = 0;
      s_div      = 1;
      pe_seen    = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         pe_seen += int'(period_end_o === 1'b1);
      end
      check("hold_no_period_end", pe_seen, 0);
      check("hold_running", running_o, 1);

      // Random stimulus against the model.
      toggle_div = 0;
      s_en       = 1;
      for (int i = 0; i < 1500; i++) begin
         s_div   = bit'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) s_en = ~s_en;
         s_valid = ($urandom_range(0, 7) == 0);
         s_duty  = 8'($urandom_range(0, 255));
         s_rst   = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
